// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 16x oversampled receive FSM with false-start rejection,
// framing-error detection and a first-word-fall-through byte FIFO.
module uart_rx_core #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int UART_BAUD  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_i,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV  = (CLK_FREQ + UART_BAUD * (OVERSAMPLE / 2)) / (UART_BAUD * OVERSAMPLE);
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = AW + 1;
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic            sync1_q, rx_s_q, rx_prev_q;
  logic [1:0]      warm_q, warm_d;
  logic [CW-1:0]   div_cnt_q, div_cnt_d;
  state_t          state_q, state_d;
  logic [3:0]      tick_cnt_q, tick_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            push_q, push_d;
  logic            ferr_q, ferr_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;

  logic tick, start_edge, full, empty, pop, wr_en;

  always_comb begin
    // Edge detection waits until the synchronizer holds real line samples,
    // so a line already low when reset is released is not taken as a start.
    start_edge = (warm_q == 2'd3) && rx_prev_q && !rx_s_q;
    tick       = (div_cnt_q == CW'(DIV - 1));
    warm_d     = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
    div_cnt_d  = tick ? '0 : div_cnt_q + CW'(1);

    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    push_d     = 1'b0;
    ferr_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d    = S_START;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          div_cnt_d  = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (tick_cnt_q == MID_TICK) begin
            tick_cnt_d = '0;
            state_d    = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d          = '0;
            shift_d[bit_cnt_q]  = rx_s_q;
            bit_cnt_d           = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = S_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            if (rx_s_q) begin
              push_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    full     = (count_q == CNTW'(FIFO_DEPTH));
    empty    = (count_q == '0);
    pop      = rx_ready && !empty;
    // A push into a full FIFO still lands when the head is popped the same cycle.
    wr_en    = push_q && (!full || pop);
    overrun  = push_q && full && !pop;
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !pop) count_d = count_q + CNTW'(1);
    if (pop && !wr_en) count_d = count_q - CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      warm_q     <= '0;
      div_cnt_q  <= '0;
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      push_q     <= 1'b0;
      ferr_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      sync1_q    <= rx_i;
      rx_s_q     <= sync1_q;
      rx_prev_q  <= rx_s_q;
      warm_q     <= warm_d;
      div_cnt_q  <= div_cnt_d;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      push_q     <= push_d;
      ferr_q     <= ferr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (wr_en) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rx_data    = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign rx_valid   = !empty;
  assign frame_err  = ferr_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomized bench for uart_rx_core: a queue-based model of the bytes the
// receiver must deliver, plus expected error-pulse counts.
`timescale 1ns/1ps
module tb_uart_rx_core;

  // Clock chosen as 128x the line rate so each bit is 128 clocks (DIV = 8),
  // keeping the 115200-baud scenarios short in clock cycles.
  localparam int  CLK_FREQ = 14_745_600;
  localparam int  BAUD     = 115200;
  localparam int  DEPTH    = 8;
  localparam real CLK_HALF = 1.0e9 / CLK_FREQ / 2.0;
  localparam real BIT_NS   = 1.0e9 / BAUD;

  logic       clk, rst, rx_i, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun;
  logic [3:0] fifo_count;

  uart_rx_core #(
    .CLK_FREQ  (CLK_FREQ),
    .UART_BAUD (BAUD),
    .OVERSAMPLE(16),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (rx_i),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #(CLK_HALF) clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_ferr = 0;
  int obs_ferr = 0;
  int exp_ovr = 0;
  int obs_ovr = 0;
  logic [7:0] mdl_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Consumer side: every pop must match the oldest byte the model expects.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err === 1'b1) obs_ferr++;
      if (overrun === 1'b1) obs_ovr++;
      if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
        chk("pop_allowed", 32'(mdl_q.size() > 0), 32'd1);
        if (mdl_q.size() > 0) chk("pop_data", {24'h0, rx_data}, {24'h0, mdl_q.pop_front()});
      end
    end
  end

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rx_ready = v;
  endtask

  // Drives one frame; stop_low > 0 holds the stop bit low for that many bit times.
  task automatic send_frame(input logic [7:0] b, input real bit_ns, input int stop_low);
    if (stop_low == 0) begin
      if (mdl_q.size() >= DEPTH) exp_ovr++;
      else mdl_q.push_back(b);
    end else begin
      exp_ferr++;
    end
    rx_i = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      #(bit_ns);
    end
    if (stop_low > 0) begin
      rx_i = 1'b0;
      #(bit_ns * stop_low);
    end
    rx_i = 1'b1;
    #(bit_ns);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_ferr"}, obs_ferr, exp_ferr);
    chk({tag, "_ovr"}, obs_ovr, exp_ovr);
    chk({tag, "_pending"}, mdl_q.size(), 0);
    chk({tag, "_count"}, {28'h0, fifo_count}, 0);
  endtask

  initial begin
    #(20_000_000);
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b81;
    real        f;
    real        tol [2];
    tol[0] = 1.025;
    tol[1] = 0.975;
    b81 = 8'h81;
    rst = 1'b1;
    rx_i = 1'b1;
    rx_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_valid", {31'h0, rx_valid}, 0);
    chk("rst_data", {24'h0, rx_data}, 0);
    chk("rst_ferr", {31'h0, frame_err}, 0);
    chk("rst_ovr", {31'h0, overrun}, 0);
    chk("rst_count", {28'h0, fifo_count}, 0);
    rst = 1'b0;
    #(BIT_NS * 2);

    send_frame(8'h41, BIT_NS, 0);
    #(BIT_NS * 2);
    check_quiet("single");

    rx_i = 1'b0;
    #(2000);
    rx_i = 1'b1;
    #(BIT_NS * 3);
    check_quiet("glitch");
    send_frame(8'h5A, BIT_NS, 0);
    #(BIT_NS * 2);
    check_quiet("after_glitch");

    send_frame(8'h55, BIT_NS, 3);
    #(BIT_NS * 2);
    check_quiet("framing");
    chk("framing_one_pulse", obs_ferr, 1);
    send_frame(8'h33, BIT_NS, 0);
    #(BIT_NS * 2);
    check_quiet("after_framing");

    set_ready(1'b0);
    for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), BIT_NS, 0);
    #(BIT_NS);
    chk("ovr_count", {28'h0, fifo_count}, DEPTH);
    chk("ovr_pulses", obs_ovr, exp_ovr);
    chk("ovr_one_pulse", obs_ovr, 1);
    chk("ovr_head", {24'h0, rx_data}, {24'h0, mdl_q[0]});
    set_ready(1'b1);
    repeat (20) @(posedge clk);
    #1;
    check_quiet("drain");

    for (int k = 0; k < 2; k++) begin
      send_frame(8'hA5, BIT_NS / tol[k], 0);
      send_frame(8'hFF, BIT_NS / tol[k], 0);
      #(BIT_NS * 2);
      check_quiet("baud_tol");
    end

    set_ready(1'b0);
    send_frame(8'h3C, BIT_NS, 0);
    #(BIT_NS);
    chk("prefill_count", {28'h0, fifo_count}, 1);
    rx_i = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 3; i++) begin
      rx_i = b81[i];
      #(BIT_NS);
    end
    rx_i = b81[3];
    #(BIT_NS / 2);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    mdl_q.delete();
    chk("midrst_valid", {31'h0, rx_valid}, 0);
    chk("midrst_data", {24'h0, rx_data}, 0);
    chk("midrst_ferr", {31'h0, frame_err}, 0);
    chk("midrst_ovr", {31'h0, overrun}, 0);
    chk("midrst_count", {28'h0, fifo_count}, 0);
    #(BIT_NS / 2);
    for (int i = 4; i < 8; i++) begin
      rx_i = b81[i];
      #(BIT_NS);
    end
    rx_i = 1'b1;
    set_ready(1'b1);
    #(BIT_NS * 2);
    check_quiet("midrst_idle");
    send_frame(8'hC3, BIT_NS, 0);
    #(BIT_NS * 2);
    check_quiet("after_midrst");

    for (int n = 0; n < 8; n++) begin
      f = 1.0 + ($itor($urandom_range(0, 40)) - 20.0) / 1000.0;
      send_frame(8'($urandom_range(0, 255)), BIT_NS / f, 0);
      #(BIT_NS * $urandom_range(0, 3));
    end
    #(BIT_NS * 2);
    check_quiet("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

UART receiver that deserializes the SoC `uart_rx` pin into bytes, the inbound counterpart of the SoC UART transmit path. Frame format is 8N1, LSB first, idle-high. It sits between the top-level `uart_rx` pad and the UART peripheral register interface. It provides a 16x oversampled receive FSM, false-start rejection, framing-error detection, and a small first-word-fall-through (FWFT) FIFO with a valid/ready output.

## Interface
- `CLK_FREQ`, 50_000_000, core clock frequency in Hz.
- `UART_BAUD`, 115200, line rate in bit/s.
- `OVERSAMPLE`, 16, sample ticks per bit; fixed at 16, other values unsupported.
- `FIFO_DEPTH`, 8, receive FIFO entries; must be a power of two, 2 to 64.

Ports:
- `clk` in 1: core clock. One clock domain only.
- `rst` in 1: reset, synchronous, active-high.
- `rx_i` in 1: asynchronous serial input, idle high.
- `rx_data` out 8: FIFO head byte; valid only while `rx_valid`=1.
- `rx_valid` out 1: FIFO non-empty.
- `rx_ready` in 1: consumer pop. A pop occurs on a clock edge where `rx_valid` and `rx_ready` are both 1.
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled low.
- `overrun` out 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: number of occupied entries.

## Operation
- **Synchronizer:** `rx_i` passes through a 2-flop synchronizer. Both flops reset to 1. All logic uses the synchronized value `rx_s`.
- **Tick generator:** `DIV = (CLK_FREQ + UART_BAUD*8) / (UART_BAUD*16)`, i.e. rounded; this gives 27 at the defaults. The divider counter pulses `tick` once every DIV clocks. It reloads to 0 on start-edge detection so bit sampling is phase-aligned to the edge.
- **FSM states:** IDLE, START, DATA, STOP, BREAK. Reset state is IDLE.
  - **IDLE:** a falling edge on `rx_s` (previous 1, current 0) moves to START and clears the tick-count and bit-count.
  - **START:** at the 8th tick (mid-bit), sample `rx_s`.
    - If 1: false start; return to IDLE and emit no output.
    - If 0: go to DATA.
  - **DATA:** every 16th tick, sample `rx_s` into `shift[bit_idx]`, LSB first. After bit 7 is sampled, go to STOP.
  - **STOP:** at the 16th tick (mid stop bit), sample `rx_s`.
    - If 1: push `shift` into the FIFO and return to IDLE immediately, so the next start edge can be caught half a bit later (back-to-back frames).
    - If 0: pulse `frame_err`, discard the byte, go to BREAK.
  - **BREAK:** wait for `rx_s`=1, then go to IDLE. A held-low line produces exactly one `frame_err`.
- **FIFO:** FWFT, circular buffer with wrap-around read/write pointers of $clog2(FIFO_DEPTH) bits.
  - `rx_data` is driven combinationally from the head entry.
  - Push while full without a simultaneous pop: byte dropped, `overrun` pulses, contents unchanged.
  - Push and pop in the same cycle while full: both accepted, count unchanged, no overrun.
  - Push and pop in the same cycle while non-full and non-empty: count unchanged.
  - Pop while empty: ignored.
- **Reset:** effective on the next clock edge.
  - FSM returns to IDLE; FIFO is emptied; any partial byte is lost.
  - After reset, reception resumes on the next clean falling edge. A line already low at reset release is not treated as a start edge.

## Timing
- **Reset values:** `rx_valid`=0, `rx_data`=0 (head entry cleared), `frame_err`=0, `overrun`=0, `fifo_count`=0.
- **Synchronizer latency:** 2 clocks from `rx_i` to `rx_s`.
- **Start-to-sample offset:** the start sample lands 8·DIV clocks after the detected edge; each later sample is 16·DIV clocks after the previous one.
- **Output latency:**
  - Push happens on the clock after the stop-sample tick.
  - `rx_valid` rises and `fifo_count` increments on the clock after the push. At the defaults, `rx_valid` rises about 216 clocks before the nominal stop-bit end.
  - `frame_err` and `overrun` are asserted for exactly one clock, on the same clock the push would have occurred.
- **Throughput:** continuous 8N1 at UART_BAUD with no gaps. Tolerates ±3% baud mismatch.
- **Handshake:** `rx_ready` may be held high permanently. `rx_data` changes only after a pop or after a push into an empty FIFO.

## Test plan
- **Single byte:** reset, then drive 0x41 at 115200 baud (8680 ns/bit), `rx_ready`=1. Expect `rx_data`=0x41 with `rx_valid` high for one clock, and no `frame_err`/`overrun`.
- **Glitch rejection:** pull `rx_i` low for 2000 ns, then release. Expect FSM back in IDLE, no `rx_valid`, no error pulses. Then send 0x5A and expect 0x5A received.
- **Framing error:** send 0x55 with the stop bit held low for 3 bit times. Expect exactly one `frame_err` pulse, `fifo_count`=0. Then send 0x33 and expect 0x33.
- **Overrun, then drain:** `rx_ready`=0, send 0x00..0x08 back-to-back with no idle gaps. Expect `fifo_count`=8, one `overrun` pulse on 0x08. Then set `rx_ready`=1 and expect 0x00..0x07 in order, with `fifo_count` reaching 0.
- **Baud tolerance:** send 0xA5 and 0xFF at 115200×1.025 and again at 115200×0.975. Expect all bytes correct, no errors.
- **Reset mid-frame:** pulse `rst` for one clock during data bit 3 of 0x81, and release `rx_i` to idle before the next frame. Expect all outputs at reset values and no byte from 0x81. The following frame 0xC3 is received correctly.
